// File: rtl/apb4_master_arbiter.sv
// Two-requester round-robin APB4 master: IDLE/SETUP/ACCESS FSM with registered outputs.
// Optional ACCESS timeout enabled by defining APB_TIMEOUT_EN.
module apb4_master_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              req_done,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_slverr,
  output logic                    busy,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t                  state;
  logic                    last_grant;
  logic                    grant;
  logic [1:0]              elig;
  logic                    pick;
  logic                    pick_valid;
  logic [ADDR_WIDTH-1:0]   pick_addr;
  logic [DATA_WIDTH-1:0]   pick_wdata;
  logic                    pick_write;

  // A requester being acknowledged this cycle has not yet dropped req_valid.
  always_comb begin
    elig       = req_valid & ~req_done;
    pick_valid = |elig;
    pick       = 1'b0;
    if (elig == 2'b11)
      pick = ~last_grant;
    else if (elig[1])
      pick = 1'b1;
    pick_addr  = pick ? req_addr[ADDR_WIDTH +: ADDR_WIDTH]  : req_addr[0 +: ADDR_WIDTH];
    pick_wdata = pick ? req_wdata[DATA_WIDTH +: DATA_WIDTH] : req_wdata[0 +: DATA_WIDTH];
    pick_write = pick ? req_write[1] : req_write[0];
  end

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  logic          timeout;
  assign timeout = (tcnt == TW'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      req_done   <= '0;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
      busy       <= 1'b0;
`ifdef APB_TIMEOUT_EN
      tcnt       <= '0;
`endif
    end else begin
      req_done <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant      <= pick;
            last_grant <= pick;
            pwrite     <= pick_write;
            paddr      <= pick_addr;
            pwdata     <= pick_wdata;
            psel       <= 1'b1;
            penable    <= 1'b0;
            busy       <= 1'b1;
            state      <= SETUP;
`ifdef APB_TIMEOUT_EN
            tcnt       <= '0;
`endif
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            psel       <= 1'b0;
            penable    <= 1'b0;
            busy       <= 1'b0;
            req_done   <= grant ? 2'b10 : 2'b01;
            rsp_slverr <= pslverr;
            if (!pwrite)
              rsp_rdata <= prdata;
            state      <= IDLE;
          end
`ifdef APB_TIMEOUT_EN
          else if (timeout) begin
            psel       <= 1'b0;
            penable    <= 1'b0;
            busy       <= 1'b0;
            req_done   <= grant ? 2'b10 : 2'b01;
            rsp_slverr <= 1'b1;
            rsp_rdata  <= '0;
            state      <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb4_master_arbiter.sv
// Scoreboard bench for apb4_master_arbiter with a configurable wait-state completer.
module tb_apb4_master_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          pclk = 1'b0;
  logic          presetn;
  logic [1:0]    req_valid, req_write, req_done;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0] rsp_rdata, pwdata, prdata;
  logic [AW-1:0] paddr;
  logic          rsp_slverr, busy, psel, penable, pwrite, pready, pslverr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            req;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;
  exp_t sb[$];
  logic [DW-1:0] model_rdata;

  int            cfg_waits;
  logic [DW-1:0] cfg_rdata;
  logic          cfg_err;
  int            wait_cnt;

  always #5 pclk = ~pclk;

  apb4_master_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr), .busy(busy),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  // Completer: inserts cfg_waits low-pready ACCESS cycles, then responds.
  always @(negedge pclk) begin
    if (psel && penable) begin
      if (wait_cnt < cfg_waits) begin
        pready = 1'b0;
        wait_cnt++;
      end else begin
        pready  = 1'b1;
        prdata  = cfg_rdata;
        pslverr = cfg_err;
      end
    end else begin
      pready   = 1'b0;
      pslverr  = 1'b0;
      prdata   = '0;
      wait_cnt = 0;
    end
  end

  task automatic set_req(input int n, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[n]          = w;
    req_addr[n*AW +: AW]  = a;
    req_wdata[n*DW +: DW] = d;
    req_valid[n]          = 1'b1;
  endtask

  task automatic push(input int n, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [DW-1:0] rd, input logic err);
    exp_t e;
    e.req = n; e.write = w; e.addr = a; e.wdata = d; e.rdata = rd; e.err = err;
    sb.push_back(e);
  endtask

  // Waits for req_done, checking the in-flight APB request against the head of the scoreboard.
  task automatic wait_done(input int budget, input logic [1:0] drop, input bit perturb, output int acc);
    exp_t          e;
    bit            got;
    logic [DW-1:0] exp_rd;
    logic [1:0]    sv_w;
    logic [2*AW-1:0] sv_a;
    logic [2*DW-1:0] sv_d;
    got = 0; acc = 0;
    sv_w = req_write; sv_a = req_addr; sv_d = req_wdata;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL sb_empty: no expected transfer queued");
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge pclk);
      if (psel) begin
        checks++;
        if ({paddr, pwrite, pwdata, busy} !== {e.addr, e.write, e.wdata, 1'b1}) begin
          errors++;
          $display("FAIL apb_req: paddr=%h pwrite=%b pwdata=%h busy=%b expected %h %b %h 1",
                   paddr, pwrite, pwdata, busy, e.addr, e.write, e.wdata);
        end
        if (penable) acc++;
        if (perturb) begin
          req_addr = ~req_addr; req_wdata = ~req_wdata; req_write = ~req_write;
        end
      end
      if (req_done != 2'b00) got = 1;
    end
    if (perturb) begin
      req_write = sv_w; req_addr = sv_a; req_wdata = sv_d;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL done_timeout: no req_done within %0d cycles for requester %0d", budget, e.req);
      return;
    end
    exp_rd = e.write ? model_rdata : e.rdata;
    model_rdata = exp_rd;
    if ({req_done, rsp_rdata, rsp_slverr, psel, penable, busy} !==
        {2'(1 << e.req), exp_rd, e.err, 3'b000}) begin
      errors++;
      $display("FAIL completion: req_done=%b rdata=%h slverr=%b psel=%b penable=%b busy=%b expected %b %h %b 000",
               req_done, rsp_rdata, rsp_slverr, psel, penable, busy, 2'(1 << e.req), exp_rd, e.err);
    end
    req_valid = req_valid & ~drop;
    @(negedge pclk);
    checks++;
    if (req_done !== 2'b00) begin
      errors++;
      $display("FAIL done_width: req_done=%b expected 00 one cycle later", req_done);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge pclk);
    checks++;
    if ({psel, penable, pwrite, paddr, pwdata, req_done, rsp_rdata, rsp_slverr, busy} !== '0) begin
      errors++;
      $display("FAIL reset_state: psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h done=%b rdata=%h err=%b busy=%b expected all 0",
               psel, penable, pwrite, paddr, pwdata, req_done, rsp_rdata, rsp_slverr, busy);
    end
    presetn = 1'b1;
  endtask

  task automatic test_contention;
    int acc;
    cfg_waits = 0; cfg_rdata = 32'h0000_1111; cfg_err = 1'b0;
    set_req(0, 1'b0, 32'h100, 32'h0);
    set_req(1, 1'b1, 32'h200, 32'hCAFE_0001);
    push(0, 1'b0, 32'h100, 32'h0, 32'h0000_1111, 1'b0);
    push(1, 1'b1, 32'h200, 32'hCAFE_0001, 32'h0, 1'b0);
    push(0, 1'b0, 32'h100, 32'h0, 32'h0000_1111, 1'b0);
    push(1, 1'b1, 32'h200, 32'hCAFE_0001, 32'h0, 1'b0);
    wait_done(10, 2'b00, 0, acc);
    wait_done(10, 2'b00, 0, acc);
    wait_done(10, 2'b00, 0, acc);
    wait_done(10, 2'b11, 0, acc);
  endtask

  task automatic test_single_write;
    int acc;
    cfg_waits = 0; cfg_err = 1'b0;
    set_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    push(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
    @(negedge pclk);
    checks++;
    if ({psel, penable, busy} !== 3'b101) begin
      errors++;
      $display("FAIL setup_phase: psel=%b penable=%b busy=%b expected 1 0 1", psel, penable, busy);
    end
    wait_done(4, 2'b01, 0, acc);
    checks++;
    if (acc !== 1) begin
      errors++;
      $display("FAIL write_latency: access cycles=%0d expected 1", acc);
    end
  endtask

  task automatic test_wait_states;
    int acc;
    cfg_waits = 3; cfg_rdata = 32'h1234_5678; cfg_err = 1'b0;
    set_req(1, 1'b0, 32'h20, 32'h5555_0000);
    push(1, 1'b0, 32'h20, 32'h5555_0000, 32'h1234_5678, 1'b0);
    wait_done(20, 2'b10, 1, acc);
    checks++;
    if (acc !== 4) begin
      errors++;
      $display("FAIL wait_access: access cycles=%0d expected 4", acc);
    end
  endtask

  task automatic test_error;
    int acc;
    cfg_waits = 1; cfg_rdata = 32'hFFFF_0000; cfg_err = 1'b1;
    set_req(0, 1'b1, 32'h40, 32'h0000_00AA);
    push(0, 1'b1, 32'h40, 32'h0000_00AA, 32'h0, 1'b1);
    wait_done(10, 2'b01, 0, acc);
    cfg_err = 1'b0;
  endtask

  task automatic test_back_to_back;
    int acc;
    cfg_waits = 0; cfg_rdata = 32'h0BAD_F00D;
    set_req(1, 1'b0, 32'h80, 32'h0);
    push(1, 1'b0, 32'h80, 32'h0, 32'h0BAD_F00D, 1'b0);
    push(1, 1'b0, 32'h80, 32'h0, 32'h0BAD_F00D, 1'b0);
    wait_done(10, 2'b00, 0, acc);
    checks++;
    if (psel !== 1'b0) begin
      errors++;
      $display("FAIL ineligible_gap: psel=%b expected 0 while req_done was high", psel);
    end
    wait_done(10, 2'b10, 0, acc);
  endtask

  task automatic test_reset_mid;
    int acc;
    cfg_waits = 5; cfg_rdata = 32'h7777_7777;
    set_req(0, 1'b0, 32'h300, 32'h0);
    for (int i = 0; i < 10 && !(psel && penable); i++) @(negedge pclk);
    checks++;
    if (!(psel && penable)) begin
      errors++;
      $display("FAIL reach_access: psel=%b penable=%b expected 1 1", psel, penable);
    end
    #2 presetn = 1'b0;
    #1;
    checks++;
    if ({psel, penable, pwrite, paddr, pwdata, req_done, rsp_rdata, rsp_slverr, busy} !== '0) begin
      errors++;
      $display("FAIL async_reset: psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h done=%b rdata=%h err=%b busy=%b expected all 0",
               psel, penable, pwrite, paddr, pwdata, req_done, rsp_rdata, rsp_slverr, busy);
    end
    model_rdata = '0;
    set_req(1, 1'b0, 32'h400, 32'h0);
    repeat (2) begin
      @(negedge pclk);
      checks++;
      if (req_done !== 2'b00) begin
        errors++;
        $display("FAIL reset_no_done: req_done=%b expected 00", req_done);
      end
    end
    cfg_waits = 0; cfg_rdata = 32'h0000_A5A5;
    push(0, 1'b0, 32'h300, 32'h0, 32'h0000_A5A5, 1'b0);
    push(1, 1'b0, 32'h400, 32'h0, 32'h0000_A5A5, 1'b0);
    presetn = 1'b1;
    wait_done(10, 2'b01, 0, acc);
    wait_done(10, 2'b10, 0, acc);
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout;
    int acc;
    cfg_waits = 1000; cfg_rdata = 32'h9999_9999;
    set_req(0, 1'b0, 32'h50, 32'h0);
    push(0, 1'b0, 32'h50, 32'h0, 32'h0, 1'b1);
    wait_done(40, 2'b01, 0, acc);
    checks++;
    if (acc !== TO) begin
      errors++;
      $display("FAIL timeout_len: access cycles=%0d expected %0d", acc, TO);
    end
    cfg_waits = 0;
  endtask
`endif

  initial begin
    presetn = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    pready = 1'b0; pslverr = 1'b0; prdata = '0; wait_cnt = 0;
    cfg_waits = 0; cfg_rdata = '0; cfg_err = 1'b0;
    model_rdata = '0;
    test_reset;
    test_contention;
    test_single_write;
    test_wait_states;
    test_error;
    test_back_to_back;
    test_reset_mid;
`ifdef APB_TIMEOUT_EN
    test_timeout;
`endif
    repeat (2) @(negedge pclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb4_master_arbiter.md
APB4_MASTER_ARBITER -- requirements
Module: apb4_master_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum ACCESS cycles with pready low (used only under APB_TIMEOUT_EN).
REQ-004 SHALL have port pclk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port presetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  2  per-requester transfer request, held until req_done.
REQ-007 SHALL have port req_write  input  2  per-requester direction, 1 = write.
REQ-008 SHALL have port req_addr  input  2*ADDR_WIDTH  requester n address in bits [n*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 SHALL have port req_wdata  input  2*DATA_WIDTH  requester n write data, packed the same way.
REQ-010 SHALL have port req_done  output  2  one-cycle completion pulse to the granted requester.
REQ-011 SHALL have port rsp_rdata  output  DATA_WIDTH  read data of the last completed transfer.
REQ-012 SHALL have port rsp_slverr  output  1  error status of the last completed transfer.
REQ-013 SHALL have port busy  output  1  high when the state is not IDLE.
REQ-014 SHALL have ports psel, penable, pwrite (output 1), paddr (output ADDR_WIDTH), pwdata (output DATA_WIDTH): APB4 master request signals.
REQ-015 SHALL have ports prdata (input DATA_WIDTH), pready (input 1), pslverr (input 1): APB4 completer response.

Function
REQ-016 SHALL implement FSM states IDLE, SETUP, ACCESS; all outputs registered.
REQ-017 IDLE: if any eligible req_valid, grant one, latch its write/addr/wdata onto pwrite/paddr/pwdata, set psel=1, penable=0, go SETUP; else stay IDLE.
REQ-018 Arbitration SHALL be round-robin: if both eligible, grant the requester not granted last; if one, grant it.
REQ-019 A requester whose req_done is high in the current cycle SHALL be ineligible in that cycle.
REQ-020 SETUP SHALL unconditionally go to ACCESS next cycle with penable=1; paddr/pwrite/pwdata/psel stable.
REQ-021 ACCESS with pready=1: psel=0, penable=0, req_done[grant]=1 for one cycle, rsp_rdata<=prdata (reads only; writes leave it unchanged), rsp_slverr<=pslverr, go IDLE.
REQ-022 ACCESS with pready=0: hold all APB outputs, stay ACCESS.
REQ-023 Minimum latency: req_valid sampled at edge 0 -> psel at edge 0, penable at edge 1, req_done at edge 2 when pready=1; one IDLE cycle between transfers.
REQ-024 paddr, pwrite, pwdata SHALL hold their last values while IDLE.
REQ-025 req_valid changes during SETUP/ACCESS SHALL not affect the transfer in flight.

Reset
REQ-026 presetn low SHALL immediately force state IDLE and psel, penable, pwrite, paddr, pwdata, req_done, rsp_rdata, rsp_slverr, busy to 0, including mid-transfer.
REQ-027 After reset, the last-granted pointer SHALL be requester 1, so requester 0 wins the first tie.

Configuration
REQ-028 Macro APB_TIMEOUT_EN defined: a counter SHALL count ACCESS cycles with pready=0; when the count reaches TIMEOUT_CYCLES, end the transfer as REQ-021 but with rsp_slverr=1 and rsp_rdata=0; counter clears on entry to SETUP.
REQ-029 Macro APB_TIMEOUT_EN undefined: ACCESS SHALL wait indefinitely for pready; no counter logic; TIMEOUT_CYCLES unused.

Verification
REQ-030 Single write: req_valid=01, write, addr 0x10, wdata 0xDEADBEEF, pready=1 -> psel edge 0, penable edge 1, req_done=01 after edge 2, rsp_slverr=0.
REQ-031 Contention: req_valid=11 held after reset -> grants 0,1,0,1 in order; each req_done one cycle wide.
REQ-032 Wait states: read, pready low 3 ACCESS cycles then high with prdata 0x12345678 -> APB outputs stable, rsp_rdata=0x12345678 with req_done.
REQ-033 Error: pslverr=1 with pready=1 -> rsp_slverr=1 with req_done.
REQ-034 Reset mid-ACCESS: presetn low -> all outputs 0 asynchronously, no req_done; next tie grants requester 0.
REQ-035 APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, pready held 0 -> req_done after 16 ACCESS cycles, rsp_slverr=1, rsp_rdata=0.
